// File: rtl/prach_ditfft3_bf1_if.sv
// rtl/prach_ditfft3_bf1_if.sv - sample stream bundle for the radix-3 first butterfly (ovf under PRACH_DITFFT3_BF1_SAT_EN)
interface prach_ditfft3_bf1_if;
  logic signed [17:0] din_dr;
  logic signed [17:0] din_di;
  logic               din_dv;
  logic               sync_in;
  logic signed [17:0] dout_dr;
  logic signed [17:0] dout_di;
  logic               dout_dv;
  logic               sync_out;
  logic               err;
`ifdef PRACH_DITFFT3_BF1_SAT_EN
  logic               ovf;
`endif

  modport master (
    output din_dr, din_di, din_dv, sync_in,
`ifdef PRACH_DITFFT3_BF1_SAT_EN
    input  ovf,
`endif
    input  dout_dr, dout_di, dout_dv, sync_out, err
  );

  modport slave (
    input  din_dr, din_di, din_dv, sync_in,
`ifdef PRACH_DITFFT3_BF1_SAT_EN
    output ovf,
`endif
    output dout_dr, dout_di, dout_dv, sync_out, err
  );
endinterface

// File: rtl/prach_ditfft3_bf1.sv
// rtl/prach_ditfft3_bf1.sv - radix-3 DIT first butterfly: (a,b,c) -> (a,b+c,b-c), triple framing police
// Optional saturation and ovf flag when PRACH_DITFFT3_BF1_SAT_EN is defined.
module prach_ditfft3_bf1 #(
  parameter int SCALE = 1
) (
  input logic             clk,
  input logic             rst_n,
  prach_ditfft3_bf1_if.slave bus
);

  typedef enum logic [1:0] {PH_A = 2'd0, PH_B = 2'd1, PH_C = 2'd2} phase_t;

  phase_t             phase;
  logic signed [17:0] a_r, a_i, b_r, b_i;
  logic               a_sync;
  logic signed [17:0] s_r, s_i, d_r, d_i;
  logic [1:0]         pend;

  logic signed [18:0] sum_r, sum_i, dif_r, dif_i;
  logic signed [17:0] p_a_r, p_a_i, p_s_r, p_s_i, p_d_r, p_d_i;

  // c is the live input when the triple completes, so b+-c are formed combinationally
  assign sum_r = {b_r[17], b_r} + {bus.din_dr[17], bus.din_dr};
  assign sum_i = {b_i[17], b_i} + {bus.din_di[17], bus.din_di};
  assign dif_r = {b_r[17], b_r} - {bus.din_dr[17], bus.din_dr};
  assign dif_i = {b_i[17], b_i} - {bus.din_di[17], bus.din_di};

  function automatic logic signed [17:0] half(input logic signed [18:0] v);
    logic signed [19:0] t;
    t = {v[18], v} + 20'sd1;
    return t[18:1];
  endfunction

  function automatic logic signed [17:0] clip(input logic signed [18:0] v);
`ifdef PRACH_DITFFT3_BF1_SAT_EN
    if (v > 19'sd131071)
      return 18'sd131071;
    else if (v < -19'sd131072)
      return -18'sd131072;
    else
      return v[17:0];
`else
    return v[17:0];
`endif
  endfunction

  always_comb begin
    if (SCALE != 0) begin
      p_a_r = half({a_r[17], a_r});
      p_a_i = half({a_i[17], a_i});
      p_s_r = half(sum_r);
      p_s_i = half(sum_i);
      p_d_r = half(dif_r);
      p_d_i = half(dif_i);
    end else begin
      p_a_r = a_r;
      p_a_i = a_i;
      p_s_r = clip(sum_r);
      p_s_i = clip(sum_i);
      p_d_r = clip(dif_r);
      p_d_i = clip(dif_i);
    end
  end

`ifdef PRACH_DITFFT3_BF1_SAT_EN
  logic ovf_s, ovf_d, ovf_s_q, ovf_d_q;
  // a 19-bit value fits 18 bits only when its top two bits agree
  assign ovf_s = (SCALE == 0) && ((sum_r[18] != sum_r[17]) || (sum_i[18] != sum_i[17]));
  assign ovf_d = (SCALE == 0) && ((dif_r[18] != dif_r[17]) || (dif_i[18] != dif_i[17]));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase        <= PH_A;
      a_r          <= '0;
      a_i          <= '0;
      b_r          <= '0;
      b_i          <= '0;
      a_sync       <= 1'b0;
      s_r          <= '0;
      s_i          <= '0;
      d_r          <= '0;
      d_i          <= '0;
      pend         <= 2'd0;
      bus.dout_dr  <= '0;
      bus.dout_di  <= '0;
      bus.dout_dv  <= 1'b0;
      bus.sync_out <= 1'b0;
      bus.err      <= 1'b0;
`ifdef PRACH_DITFFT3_BF1_SAT_EN
      ovf_s_q      <= 1'b0;
      ovf_d_q      <= 1'b0;
      bus.ovf      <= 1'b0;
`endif
    end else begin
      bus.dout_dv  <= 1'b0;
      bus.sync_out <= 1'b0;
      bus.err      <= 1'b0;
`ifdef PRACH_DITFFT3_BF1_SAT_EN
      bus.ovf      <= 1'b0;
`endif
      // drain b+c then b-c; a new triple cannot complete before this finishes
      if (pend == 2'd2) begin
        bus.dout_dr <= s_r;
        bus.dout_di <= s_i;
        bus.dout_dv <= 1'b1;
        pend        <= 2'd1;
`ifdef PRACH_DITFFT3_BF1_SAT_EN
        bus.ovf     <= ovf_s_q;
`endif
      end else if (pend == 2'd1) begin
        bus.dout_dr <= d_r;
        bus.dout_di <= d_i;
        bus.dout_dv <= 1'b1;
        pend        <= 2'd0;
`ifdef PRACH_DITFFT3_BF1_SAT_EN
        bus.ovf     <= ovf_d_q;
`endif
      end

      if (bus.din_dv) begin
        if (bus.sync_in || phase == PH_A) begin
          a_r    <= bus.din_dr;
          a_i    <= bus.din_di;
          a_sync <= bus.sync_in;
          phase  <= PH_B;
          if (phase != PH_A)
            bus.err <= 1'b1;
        end else if (phase == PH_B) begin
          b_r   <= bus.din_dr;
          b_i   <= bus.din_di;
          phase <= PH_C;
        end else begin
          bus.dout_dr  <= p_a_r;
          bus.dout_di  <= p_a_i;
          bus.dout_dv  <= 1'b1;
          bus.sync_out <= a_sync;
          s_r          <= p_s_r;
          s_i          <= p_s_i;
          d_r          <= p_d_r;
          d_i          <= p_d_i;
          pend         <= 2'd2;
          phase        <= PH_A;
`ifdef PRACH_DITFFT3_BF1_SAT_EN
          ovf_s_q      <= ovf_s;
          ovf_d_q      <= ovf_d;
`endif
        end
      end else if (phase != PH_A) begin
        phase   <= PH_A;
        bus.err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prach_ditfft3_bf1.sv
// tb/tb_prach_ditfft3_bf1.sv - directed bench: unscaled (SCALE=0) and scaled (SCALE=1) instances share one stimulus
module tb_prach_ditfft3_bf1;
  logic clk;
  logic rst_n;
  logic signed [17:0] din_dr, din_di;
  logic din_dv, sync_in;
  int n_pass, n_fail, n_total;

  prach_ditfft3_bf1_if bus0 ();
  prach_ditfft3_bf1_if bus1 ();

  assign bus0.din_dr  = din_dr;
  assign bus0.din_di  = din_di;
  assign bus0.din_dv  = din_dv;
  assign bus0.sync_in = sync_in;
  assign bus1.din_dr  = din_dr;
  assign bus1.din_di  = din_di;
  assign bus1.din_dv  = din_dv;
  assign bus1.sync_in = sync_in;

  prach_ditfft3_bf1 #(.SCALE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  prach_ditfft3_bf1 #(.SCALE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int dr, input int di, input logic dv, input logic sy);
    din_dr  = dr[17:0];
    din_di  = di[17:0];
    din_dv  = dv;
    sync_in = sy;
    tick();
  endtask

  task automatic chk0(input string tag, input int dr, input int di, input logic dv, input logic so);
    chk({tag, ".dr"}, $signed(bus0.dout_dr), dr);
    chk({tag, ".di"}, $signed(bus0.dout_di), di);
    chk({tag, ".dv"}, {31'd0, bus0.dout_dv}, {31'd0, dv});
    chk({tag, ".sync"}, {31'd0, bus0.sync_out}, {31'd0, so});
  endtask

  task automatic chk1(input string tag, input int dr, input int di, input logic dv);
    chk({tag, ".dr"}, $signed(bus1.dout_dr), dr);
    chk({tag, ".di"}, $signed(bus1.dout_di), di);
    chk({tag, ".dv"}, {31'd0, bus1.dout_dv}, {31'd0, dv});
  endtask

  initial begin
    int q_r[$];
    int q_i[$];
    int tr_r[3];
    int tr_i[3];
    logic pat[25];
    int n, ph, outs, er, ei;

    n_pass = 0; n_fail = 0; n_total = 0;
    rst_n = 1'b0;
    din_dr = '0; din_di = '0; din_dv = 1'b0; sync_in = 1'b0;
    repeat (3) tick();
    chk0("rst", 0, 0, 1'b0, 1'b0);
    chk("rst.err", {31'd0, bus0.err}, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk0("idle", 0, 0, 1'b0, 1'b0);
    chk("idle.err", {31'd0, bus0.err}, 0);

    // unscaled triple with sync on a
    drive(100, -50, 1'b1, 1'b1);
    drive(1000, 3, 1'b1, 1'b0);
    drive(-200, 7, 1'b1, 1'b0);
    chk0("s0.a", 100, -50, 1'b1, 1'b1);
    chk("s0.a.err", {31'd0, bus0.err}, 0);
    drive(0, 0, 1'b0, 1'b0);
    chk0("s0.sum", 800, 10, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    chk0("s0.dif", 1200, -4, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    chk0("s0.hold", 1200, -4, 1'b0, 1'b0);

    // scaled triple, round half up
    drive(3, -3, 1'b1, 1'b0);
    drive(5, 0, 1'b1, 1'b0);
    drive(-2, 1, 1'b1, 1'b0);
    chk1("s1.a", 2, -1, 1'b1);
    drive(0, 0, 1'b0, 1'b0);
    chk1("s1.sum", 2, 1, 1'b1);
    drive(0, 0, 1'b0, 1'b0);
    chk1("s1.dif", 4, 0, 1'b1);
    drive(0, 0, 1'b0, 1'b0);
    chk1("s1.idle", 4, 0, 1'b0);

    // four back-to-back triples, 2-cycle gap, two more
    for (int k = 0; k < 25; k++) pat[k] = (k < 12) || (k >= 14 && k < 20);
    n = 0; ph = 0; outs = 0;
    for (int k = 0; k < 25; k++) begin
      if (pat[k]) begin
        tr_r[ph] = n * 10 + 1;
        tr_i[ph] = -n;
        n++;
        if (ph == 2) begin
          q_r.push_back(tr_r[0]);            q_i.push_back(tr_i[0]);
          q_r.push_back(tr_r[1] + tr_r[2]);  q_i.push_back(tr_i[1] + tr_i[2]);
          q_r.push_back(tr_r[1] - tr_r[2]);  q_i.push_back(tr_i[1] - tr_i[2]);
          ph = 0;
        end else ph++;
        drive(tr_r[(ph + 2) % 3 == 2 && ph == 0 ? 2 : (ph + 2) % 3], tr_i[(ph == 0) ? 2 : ph - 1], 1'b1, 1'b0);
      end else begin
        drive(0, 0, 1'b0, 1'b0);
      end
      chk($sformatf("str.dv%0d", k), {31'd0, bus0.dout_dv}, (k >= 2) ? {31'd0, pat[k - 2]} : 0);
      chk($sformatf("str.err%0d", k), {31'd0, bus0.err}, 0);
      if (bus0.dout_dv === 1'b1) begin
        outs++;
        if (q_r.size() > 0) begin
          er = q_r.pop_front();
          ei = q_i.pop_front();
          chk($sformatf("str.dr%0d", k), $signed(bus0.dout_dr), er);
          chk($sformatf("str.di%0d", k), $signed(bus0.dout_di), ei);
        end
      end
    end
    chk("str.count", outs, 18);

    // din_dv drops after b
    drive(10, 20, 1'b1, 1'b0);
    drive(30, 40, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    chk("v1.err", {31'd0, bus0.err}, 1);
    chk("v1.dv", {31'd0, bus0.dout_dv}, 0);
    drive(0, 0, 1'b0, 1'b0);
    chk("v1.err_once", {31'd0, bus0.err}, 0);
    chk("v1.dv2", {31'd0, bus0.dout_dv}, 0);
    drive(1, 2, 1'b1, 1'b0);
    drive(3, 4, 1'b1, 1'b0);
    drive(5, 6, 1'b1, 1'b0);
    chk0("v1.a", 1, 2, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    chk0("v1.sum", 8, 10, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    chk0("v1.dif", -2, -2, 1'b1, 1'b0);

    // sync lands on the c slot and reframes
    drive(7, 7, 1'b1, 1'b1);
    drive(8, 8, 1'b1, 1'b0);
    drive(50, -60, 1'b1, 1'b1);
    chk("v2.err", {31'd0, bus0.err}, 1);
    chk("v2.dv", {31'd0, bus0.dout_dv}, 0);
    drive(11, 12, 1'b1, 1'b0);
    chk("v2.err_once", {31'd0, bus0.err}, 0);
    chk("v2.dv2", {31'd0, bus0.dout_dv}, 0);
    drive(4, -3, 1'b1, 1'b0);
    chk0("v2.a", 50, -60, 1'b1, 1'b1);
    drive(0, 0, 1'b0, 1'b0);
    chk0("v2.sum", 15, 9, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    chk0("v2.dif", 7, 15, 1'b1, 1'b0);

    // reset mid-triple
    drive(9, 9, 1'b1, 1'b0);
    drive(9, 9, 1'b1, 1'b0);
    rst_n = 1'b0;
    drive(0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1'b0, 1'b0);
      chk($sformatf("mrst.dv%0d", k), {31'd0, bus0.dout_dv}, 0);
      chk($sformatf("mrst.err%0d", k), {31'd0, bus0.err}, 0);
    end

    // full-scale b=c, unscaled
    drive(0, 0, 1'b1, 1'b0);
    drive(131071, -131072, 1'b1, 1'b0);
    drive(131071, -131072, 1'b1, 1'b0);
    chk0("ovf.a", 0, 0, 1'b1, 1'b0);
`ifdef PRACH_DITFFT3_BF1_SAT_EN
    chk("ovf.a.flag", {31'd0, bus0.ovf}, 0);
    drive(0, 0, 1'b0, 1'b0);
    chk0("ovf.sum", 131071, -131072, 1'b1, 1'b0);
    chk("ovf.sum.flag", {31'd0, bus0.ovf}, 1);
    chk("ovf.s1.flag", {31'd0, bus1.ovf}, 0);
    drive(0, 0, 1'b0, 1'b0);
    chk0("ovf.dif", 0, 0, 1'b1, 1'b0);
    chk("ovf.dif.flag", {31'd0, bus0.ovf}, 0);
`else
    drive(0, 0, 1'b0, 1'b0);
    chk0("wrap.sum", -2, 0, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    chk0("wrap.dif", 0, 0, 1'b1, 1'b0);
`endif
    drive(0, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
